dbus_arbiter: RTL and testbench
===============================

DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of both masters and the slave port.
REQ-002 Parameter DATA_W, default 32, data width of both masters and the slave port.
REQ-003 Parameter FIXED_PRIO, default 0; 0 = round-robin arbitration, 1 = m0 always wins.
REQ-004 Parameter LOCK_MAX, default 16, maximum consecutive locked grants per master.
REQ-005 Port list (clock and reset first); it SHALL be exactly:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- mN_req  in  1  master N (N=0,1) transaction request; held until accepted.
- mN_we  in  1  master N: 1 = write, 0 = read.
- mN_addr  in  ADDR_W  master N byte address.
- mN_wdata  in  DATA_W  master N write data.
- mN_lock  in  1  master N requests grant retention for its next transaction.
- mN_ready  out  1  master N request accepted this cycle.
- mN_rvalid  out  1  master N read data valid.
- mN_rdata  out  DATA_W  master N read data.
- s_wr  out  1  slave write strobe.
- s_waddr  out  ADDR_W  slave write address.
- s_wdata  out  DATA_W  slave write data.
- s_rd  out  1  slave read strobe.
- s_raddr  out  ADDR_W  slave read address.
- s_rdata  in  DATA_W  slave read data, valid exactly one cycle after s_rd.

Function
REQ-006 The block SHALL accept at most one transaction per cycle; mN_ready SHALL be combinational from the current requests and the arbiter state, and at most one mN_ready SHALL be high.
REQ-007 An accepted write SHALL drive s_wr=1, s_waddr and s_wdata from the winner in the same cycle; an accepted read SHALL drive s_rd=1 and s_raddr in the same cycle; s_wr and s_rd SHALL never both be high.
REQ-008 Outside accepted cycles: s_wr=0, s_rd=0, s_waddr/s_raddr/s_wdata=0.
REQ-009 A read-owner register SHALL capture the winner of each accepted read; the next cycle, that master's mN_rvalid=1 and mN_rdata=s_rdata, while the other master sees rvalid=0 and rdata=0.
REQ-010 Back-to-back reads SHALL be accepted every cycle with no bubble; each rvalid follows its own accept by exactly one cycle.
REQ-011 Round-robin (FIXED_PRIO=0): a last-grant pointer, updated on every accept, SHALL give priority to the master not granted last; with a single requester, that requester wins.
REQ-012 FIXED_PRIO=1: m0 SHALL win whenever m0_req=1.
REQ-013 Lock FSM, states IDLE and LOCKED(owner): IDLE->LOCKED when the accepted transaction has mN_lock=1; in LOCKED, only the owner can be granted and the other master stalls.
REQ-014 LOCKED->IDLE when the owner completes a transaction with lock=0, or when owner_req=0 for one cycle.
REQ-015 LOCKED->IDLE also when the lock counter, counting locked grants, reaches LOCK_MAX; that release SHALL be forced after the LOCK_MAX-th locked grant, and the pointer then SHALL favour the other master.
REQ-016 Lock counter width SHALL be $clog2(LOCK_MAX+1); the counter SHALL clear on entry to IDLE and never wrap.

Reset
REQ-017 While rstn=0, all outputs SHALL be 0, the FSM SHALL be IDLE, the pointer SHALL favour m0, the read owner and read pending SHALL be cleared, and the lock counter SHALL be 0.
REQ-018 Reset asserted mid-read SHALL drop the pending rvalid; no rvalid SHALL appear after reset release without a new accept.

Structure
REQ-019 Package dbus_pkg SHALL hold the master-count constant (2), the lock FSM state encoding, and the default widths; BASEADDR/mask constants of the data bus SHALL move there too.
REQ-020 The block SHALL be a single flat module; no sub-module is required.

Verification
REQ-021 m0 and m1 both request a read every cycle (FIXED_PRIO=0) -> grants alternate m0,m1,m0,...; each rvalid is one cycle after its ready, with the correct rdata routed.
REQ-022 m1 writes 0x0000_00A5 to 0x0300_0000 alone -> m1_ready=1, s_wr=1 and s_waddr=0x0300_0000 in the same cycle; no rvalid.
REQ-023 m0 holds lock=1 with continuous requests while m1 requests -> m0 gets exactly 16 grants, then m1 is granted next.
REQ-024 FIXED_PRIO=1, both requesting for 5 cycles -> m0 gets all 5 grants; m1 is granted in cycle 6 after m0 drops req.
REQ-025 m0 read accepted, then rstn pulsed low the next cycle -> m0_rvalid=0 throughout and after release; all slave strobes are 0.

Source files
------------

// File: rtl/dbus_pkg.sv
// ============================================================================
// Module   : dbus_pkg
// Purpose  : Shared constants, lock FSM encoding and address-map helpers for
//            the two-master data-bus arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dbus_pkg;

    localparam int N_MASTERS    = 2;
    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_LOCK_MAX = 16;

    // Data-bus address window, shared by every block that decodes the bus.
    localparam logic [DEF_ADDR_W-1:0] DBUS_BASEADDR  = 32'h0300_0000;
    localparam logic [DEF_ADDR_W-1:0] DBUS_ADDR_MASK = 32'hFF00_0000;

    typedef enum logic [0:0] {
        LK_IDLE   = 1'b0,
        LK_LOCKED = 1'b1
    } lock_state_e;

    function automatic logic in_dbus_window(input logic [DEF_ADDR_W-1:0] addr);
        return (addr & DBUS_ADDR_MASK) == DBUS_BASEADDR;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dbus_arbiter_if.sv
// ============================================================================
// Module   : dbus_arbiter_if
// Purpose  : Bundles both master ports and the slave port of the data bus.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface dbus_arbiter_if #(
    parameter int ADDR_W = dbus_pkg::DEF_ADDR_W,
    parameter int DATA_W = dbus_pkg::DEF_DATA_W
) ();
    import dbus_pkg::*;

    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_lock;
    logic              m0_ready;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_lock;
    logic              m1_ready;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              s_wr;
    logic [ADDR_W-1:0] s_waddr;
    logic [DATA_W-1:0] s_wdata;
    logic              s_rd;
    logic [ADDR_W-1:0] s_raddr;
    logic [DATA_W-1:0] s_rdata;

    // Requesting side: both masters.
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m0_ready, m0_rvalid, m0_rdata,
        input  m1_ready, m1_rvalid, m1_rdata
    );

    // Responding side: the single downstream slave.
    modport slave (
        input  s_wr, s_waddr, s_wdata, s_rd, s_raddr,
        output s_rdata
    );

    // The arbiter sits between the two.
    modport arbiter (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m0_ready, m0_rvalid, m0_rdata,
        output m1_ready, m1_rvalid, m1_rdata,
        output s_wr, s_waddr, s_wdata, s_rd, s_raddr,
        input  s_rdata
    );

endinterface

`default_nettype wire

// File: rtl/dbus_arbiter.sv
// ============================================================================
// Module   : dbus_arbiter
// Purpose  : Two-master to one-slave data-bus arbiter with round-robin or
//            fixed priority, bounded bus locking and single-cycle read return.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dbus_arbiter #(
    parameter int ADDR_W     = dbus_pkg::DEF_ADDR_W,
    parameter int DATA_W     = dbus_pkg::DEF_DATA_W,
    parameter int FIXED_PRIO = 0,
    parameter int LOCK_MAX   = dbus_pkg::DEF_LOCK_MAX
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_ready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_ready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              s_wr,
    output logic [ADDR_W-1:0] s_waddr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_rd,
    output logic [ADDR_W-1:0] s_raddr,
    input  logic [DATA_W-1:0] s_rdata
);
    import dbus_pkg::*;

    localparam int              CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    lock_state_e          state_q,    state_d;
    logic                 owner_q,    owner_d;
    logic                 last_q,     last_d;
    logic [CNT_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic                 rd_pend_q,  rd_pend_d;
    logic                 rd_owner_q, rd_owner_d;

    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] req_lock;
    logic [N_MASTERS-1:0] gnt;
    logic                 accept;
    logic                 win;
    logic                 win_we;
    logic                 win_lock;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;
    logic [CNT_W-1:0]     lock_cnt_inc;

    assign req      = {m1_req,  m0_req};
    assign req_lock = {m1_lock, m0_lock};

    // Grant selection; held at zero during reset so every output reads 0.
    always_comb begin
        gnt = '0;
        if (rstn) begin
            if (state_q == LK_LOCKED) begin
                if (req[owner_q]) begin
                    gnt[owner_q] = 1'b1;
                end
            end else if (FIXED_PRIO != 0) begin
                if (req[0]) begin
                    gnt[0] = 1'b1;
                end else if (req[1]) begin
                    gnt[1] = 1'b1;
                end
            end else if (req[0] && req[1]) begin
                gnt[~last_q] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    assign accept    = |gnt;
    assign win       = gnt[1];
    assign win_we    = win ? m1_we    : m0_we;
    assign win_lock  = req_lock[win];
    assign win_addr  = win ? m1_addr  : m0_addr;
    assign win_wdata = win ? m1_wdata : m0_wdata;

    assign m0_ready = gnt[0];
    assign m1_ready = gnt[1];

    assign s_wr    = accept &  win_we;
    assign s_rd    = accept & ~win_we;
    assign s_waddr = s_wr ? win_addr  : '0;
    assign s_wdata = s_wr ? win_wdata : '0;
    assign s_raddr = s_rd ? win_addr  : '0;

    // Read data is routed only to the master whose read was accepted last cycle.
    assign m0_rvalid = rd_pend_q & ~rd_owner_q;
    assign m1_rvalid = rd_pend_q &  rd_owner_q;
    assign m0_rdata  = m0_rvalid ? s_rdata : '0;
    assign m1_rdata  = m1_rvalid ? s_rdata : '0;

    assign lock_cnt_inc = lock_cnt_q + CNT_ONE;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        last_d     = last_q;
        rd_pend_d  = s_rd;
        rd_owner_d = s_rd ? win : rd_owner_q;

        if (accept) begin
            last_d = win;
        end

        case (state_q)
            LK_IDLE: begin
                if (accept && win_lock) begin
                    // With LOCK_MAX of 1 the very first locked grant already exhausts the budget.
                    if (lock_cnt_inc == CNT_MAX) begin
                        lock_cnt_d = '0;
                    end else begin
                        state_d    = LK_LOCKED;
                        owner_d    = win;
                        lock_cnt_d = lock_cnt_inc;
                    end
                end
            end
            LK_LOCKED: begin
                if (!req[owner_q]) begin
                    state_d    = LK_IDLE;
                    lock_cnt_d = '0;
                end else if (accept) begin
                    if (!win_lock || (lock_cnt_inc == CNT_MAX)) begin
                        state_d    = LK_IDLE;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_inc;
                    end
                end
            end
            default: begin
                state_d    = LK_IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    // last_q=1 means m1 was granted last, so m0 is favoured out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= LK_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dbus_arbiter.sv
// ============================================================================
// Module   : tb_dbus_arbiter
// Purpose  : Randomized scoreboard bench for dbus_arbiter (round-robin and
//            fixed-priority instances) against a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dbus_arbiter;
    import dbus_pkg::*;

    localparam int LOCK_MAX = 16;

    typedef struct {
        int          g;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } gexp_t;

    typedef struct {
        int          m;
        logic [31:0] data;
        int          cyc;
    } rexp_t;

    logic clk;
    logic rstn;

    dbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus  ();
    dbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) fbus ();

    dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .LOCK_MAX(LOCK_MAX)) u_dut (
        .clk(clk), .rstn(rstn),
        .m0_req(bus.m0_req), .m0_we(bus.m0_we), .m0_addr(bus.m0_addr), .m0_wdata(bus.m0_wdata),
        .m0_lock(bus.m0_lock), .m0_ready(bus.m0_ready), .m0_rvalid(bus.m0_rvalid), .m0_rdata(bus.m0_rdata),
        .m1_req(bus.m1_req), .m1_we(bus.m1_we), .m1_addr(bus.m1_addr), .m1_wdata(bus.m1_wdata),
        .m1_lock(bus.m1_lock), .m1_ready(bus.m1_ready), .m1_rvalid(bus.m1_rvalid), .m1_rdata(bus.m1_rdata),
        .s_wr(bus.s_wr), .s_waddr(bus.s_waddr), .s_wdata(bus.s_wdata),
        .s_rd(bus.s_rd), .s_raddr(bus.s_raddr), .s_rdata(bus.s_rdata)
    );

    dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .LOCK_MAX(LOCK_MAX)) u_dut_fp (
        .clk(clk), .rstn(rstn),
        .m0_req(fbus.m0_req), .m0_we(fbus.m0_we), .m0_addr(fbus.m0_addr), .m0_wdata(fbus.m0_wdata),
        .m0_lock(fbus.m0_lock), .m0_ready(fbus.m0_ready), .m0_rvalid(fbus.m0_rvalid), .m0_rdata(fbus.m0_rdata),
        .m1_req(fbus.m1_req), .m1_we(fbus.m1_we), .m1_addr(fbus.m1_addr), .m1_wdata(fbus.m1_wdata),
        .m1_lock(fbus.m1_lock), .m1_ready(fbus.m1_ready), .m1_rvalid(fbus.m1_rvalid), .m1_rdata(fbus.m1_rdata),
        .s_wr(fbus.s_wr), .s_waddr(fbus.s_waddr), .s_wdata(fbus.s_wdata),
        .s_rd(fbus.s_rd), .s_raddr(fbus.s_raddr), .s_rdata(fbus.s_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    gexp_t gq[$];
    rexp_t rq[$];
    logic [1:0] fq[$];

    // Pending transaction of each master, held until the model grants it.
    bit          p_req  [2];
    bit          p_we   [2];
    bit          p_lock [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_data [2];

    // Transaction-level arbitration model.
    bit m_locked;
    int m_owner;
    int m_count;
    int m_prefer;

    function automatic logic [31:0] slave_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_count  = 0;
        m_prefer = 0;
    endfunction

    function automatic int model_pick();
        if (m_locked) return p_req[m_owner] ? m_owner : -1;
        if (p_req[0] && p_req[1]) return m_prefer;
        if (p_req[0]) return 0;
        if (p_req[1]) return 1;
        return -1;
    endfunction

    function automatic void model_update(input int g);
        if (m_locked && !p_req[m_owner]) begin
            m_locked = 1'b0;
            m_count  = 0;
            return;
        end
        if (g < 0) return;
        m_prefer = 1 - g;
        if (p_lock[g]) begin
            m_count++;
            if (m_count >= LOCK_MAX) begin
                m_locked = 1'b0;
                m_count  = 0;
            end else begin
                m_locked = 1'b1;
                m_owner  = g;
            end
        end else begin
            m_locked = 1'b0;
            m_count  = 0;
        end
    endfunction

    task automatic gen(input int m, input int preq, input int pwe, input int plk);
        if (!p_req[m] && ($urandom_range(99) < preq)) begin
            p_req[m]  = 1'b1;
            p_we[m]   = ($urandom_range(99) < pwe);
            p_lock[m] = ($urandom_range(99) < plk);
            p_addr[m] = $urandom;
            p_data[m] = $urandom;
        end
    endtask

    // One bus cycle: apply inputs, predict the response, advance the model.
    task automatic drive_cycle(input bit rst_active);
        gexp_t e;
        int    g;
        @(posedge clk);
        #1;
        cyc++;
        rstn         = ~rst_active;
        bus.m0_req   = p_req[0];  bus.m0_we   = p_we[0];   bus.m0_lock  = p_lock[0];
        bus.m0_addr  = p_addr[0]; bus.m0_wdata = p_data[0];
        bus.m1_req   = p_req[1];  bus.m1_we   = p_we[1];   bus.m1_lock  = p_lock[1];
        bus.m1_addr  = p_addr[1]; bus.m1_wdata = p_data[1];
        g = rst_active ? -1 : model_pick();
        e.g    = g;
        e.we   = (g >= 0) ? p_we[g]   : 1'b0;
        e.addr = (g >= 0) ? p_addr[g] : '0;
        e.data = (g >= 0) ? p_data[g] : '0;
        gq.push_back(e);
        if (rst_active) begin
            model_reset();
            rq.delete();
        end else begin
            if (g >= 0 && !p_we[g]) begin
                rexp_t r;
                r.m    = g;
                r.data = slave_f(p_addr[g]);
                r.cyc  = cyc + 1;
                rq.push_back(r);
            end
            model_update(g);
            if (g >= 0) p_req[g] = 1'b0;
        end
    endtask

    // Slave responder: read data is valid the cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (bus.s_rd) bus.s_rdata <= slave_f(bus.s_raddr);
        else          bus.s_rdata <= $urandom;
    end

    gexp_t      me;
    rexp_t      mr;
    logic [1:0] exp_rv;
    logic [31:0] exp_rdata;
    logic [1:0] exp_rdy;

    always @(negedge clk) begin
        if (gq.size() > 0) begin
            me      = gq.pop_front();
            exp_rdy = (me.g == 0) ? 2'b01 : (me.g == 1) ? 2'b10 : 2'b00;
            chk("ready",   {bus.m1_ready, bus.m0_ready}, exp_rdy);
            chk("s_wr",    bus.s_wr,    (me.g >= 0) &&  me.we);
            chk("s_rd",    bus.s_rd,    (me.g >= 0) && !me.we);
            chk("s_waddr", bus.s_waddr, ((me.g >= 0) &&  me.we) ? me.addr : 32'h0);
            chk("s_wdata", bus.s_wdata, ((me.g >= 0) &&  me.we) ? me.data : 32'h0);
            chk("s_raddr", bus.s_raddr, ((me.g >= 0) && !me.we) ? me.addr : 32'h0);
        end
        exp_rv    = 2'b00;
        exp_rdata = '0;
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            mr        = rq.pop_front();
            exp_rv    = (mr.m == 0) ? 2'b01 : 2'b10;
            exp_rdata = mr.data;
        end
        chk("rvalid",   {bus.m1_rvalid, bus.m0_rvalid}, exp_rv);
        chk("m0_rdata", bus.m0_rdata, exp_rv[0] ? exp_rdata : 32'h0);
        chk("m1_rdata", bus.m1_rdata, exp_rv[1] ? exp_rdata : 32'h0);
    end

    always @(negedge clk) begin
        if (fq.size() > 0) begin
            chk("fp_ready", {fbus.m1_ready, fbus.m0_ready}, fq.pop_front());
            chk("fp_s_rd",  fbus.s_rd, 1'b1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        bit seen;
        rstn = 1'b0;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            p_req[m] = 0; p_we[m] = 0; p_lock[m] = 0; p_addr[m] = '0; p_data[m] = '0;
        end
        bus.s_rdata  = '0;
        fbus.m0_req  = 0; fbus.m0_we = 0; fbus.m0_addr = '0; fbus.m0_wdata = '0; fbus.m0_lock = 0;
        fbus.m1_req  = 0; fbus.m1_we = 0; fbus.m1_addr = '0; fbus.m1_wdata = '0; fbus.m1_lock = 0;
        fbus.s_rdata = '0;

        // Requests held during reset must not be granted.
        gen(0, 100, 50, 0);
        gen(1, 100, 50, 0);
        repeat (3) drive_cycle(1'b1);
        repeat (4) drive_cycle(1'b0);

        // Both masters reading every cycle.
        for (int i = 0; i < 20; i++) begin
            gen(0, 100, 0, 0);
            gen(1, 100, 0, 0);
            drive_cycle(1'b0);
        end
        repeat (6) drive_cycle(1'b0);

        // Lone write from m1.
        p_req[1] = 1; p_we[1] = 1; p_lock[1] = 0; p_addr[1] = 32'h0300_0000; p_data[1] = 32'h0000_00A5;
        drive_cycle(1'b0);
        repeat (2) drive_cycle(1'b0);

        // m0 keeps the bus locked while m1 waits: budget then hand-over.
        n0   = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (!p_req[0]) begin
                p_req[0] = 1; p_we[0] = 0; p_lock[0] = 1; p_addr[0] = $urandom; p_data[0] = $urandom;
            end
            if (!p_req[1]) begin
                p_req[1] = 1; p_we[1] = 0; p_lock[1] = 0; p_addr[1] = $urandom; p_data[1] = $urandom;
            end
            drive_cycle(1'b0);
            @(negedge clk);
            if (bus.m1_ready)      seen = 1'b1;
            else if (bus.m0_ready) n0++;
        end
        chk("lock_handover_seen", seen, 1'b1);
        chk("lock_m0_grants", n0, LOCK_MAX);
        p_req[0] = 0;
        repeat (6) drive_cycle(1'b0);

        // Randomized traffic with locks, gaps and mixed read/write.
        for (int i = 0; i < 400; i++) begin
            gen(0, 60, 40, 30);
            gen(1, 60, 40, 30);
            drive_cycle(1'b0);
        end
        repeat (6) drive_cycle(1'b0);

        // Reset pulsed right after an accepted read drops the return.
        p_req[0] = 1; p_we[0] = 0; p_lock[0] = 0; p_addr[0] = 32'h1234_5678;
        p_req[1] = 0;
        drive_cycle(1'b0);
        repeat (2) drive_cycle(1'b1);
        repeat (3) drive_cycle(1'b0);

        // Fixed-priority instance: m0 wins while requesting, then m1.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            fbus.m0_req  = (i < 5);
            fbus.m0_addr = 32'h100 + i;
            fbus.m1_req  = 1'b1;
            fbus.m1_addr = 32'h200;
            fq.push_back((i < 5) ? 2'b01 : 2'b10);
        end
        @(posedge clk);
        #1;
        fbus.m0_req = 1'b0;
        fbus.m1_req = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("grant_queue_drained", gq.size(), 0);
        chk("read_queue_drained",  rq.size(), 0);
        chk("fp_queue_drained",    fq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
